comparator_arbiter: RTL and testbench

COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

---
 rtl/comparator_arbiter.sv | 114 +++++++++++
 tb/tb_comparator_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_arbiter.sv
// ============================================================================
// Module   : comparator_arbiter
// Desc     : Two-requester arbitrated unsigned comparator with registered flags.
//            Define ROUND_ROBIN_EN for alternating grants on contention;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic [WIDTH-1:0] valA0,
  input  logic [WIDTH-1:0] valB0,
  input  logic             req1,
  input  logic [WIDTH-1:0] valA1,
  input  logic [WIDTH-1:0] valB1,
  output logic [5:0]       flags,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [7:0]       cmp_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_gnt;

  logic             w_any_req;
  logic             w_gnt;
  logic             w_gt;
  logic             w_lt;
  logic             w_eq;

  assign w_any_req = req0 | req1;

`ifdef ROUND_ROBIN_EN
  logic r_last_gnt;

  // On contention the requester not served last wins; a lone request always wins.
  assign w_gnt = (req0 && req1) ? ~r_last_gnt : req1;
`else
  assign w_gnt = ~req0 & req1;
`endif

  assign w_gt = (r_opa >  r_opb);
  assign w_lt = (r_opa <  r_opb);
  assign w_eq = (r_opa == r_opb);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_gnt     <= 1'b0;
      flags     <= 6'b000000;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      cmp_count <= 8'd0;
`ifdef ROUND_ROBIN_EN
      r_last_gnt <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_gnt;
            r_opa   <= w_gnt ? valA1 : valA0;
            r_opb   <= w_gnt ? valB1 : valB0;
            busy    <= 1'b1;
            r_state <= S_EVAL;
`ifdef ROUND_ROBIN_EN
            r_last_gnt <= w_gnt;
`endif
          end
        end
        S_EVAL: begin
          // bit order: aGTb, aGEb, aLTb, aLEb, aEQb, aNEb
          flags     <= {w_gt, ~w_lt, w_lt, ~w_gt, w_eq, ~w_eq};
          done0     <= ~r_gnt;
          done1     <= r_gnt;
          cmp_count <= cmp_count + 8'd1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comparator_arbiter.sv
// ============================================================================
// Module   : tb_comparator_arbiter
// Desc     : Scoreboard bench for comparator_arbiter (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_comparator_arbiter;

  logic       CLK;
  logic       RST;
  logic       req0, req1;
  logic [2:0] valA0, valB0, valA1, valB1;
  logic [5:0] flags;
  logic       done0, done1, busy;
  logic [7:0] cmp_count;

  typedef struct {
    bit         port;
    logic [5:0] flags;
    logic [7:0] count;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_count = 8'd0;

  comparator_arbiter #(.WIDTH(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req0      (req0),
    .valA0     (valA0),
    .valB0     (valB0),
    .req1      (req1),
    .valA1     (valA1),
    .valB1     (valB1),
    .flags     (flags),
    .done0     (done0),
    .done1     (done1),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference flags from plain unsigned comparison
  function automatic logic [5:0] ref_flags(input logic [2:0] a, input logic [2:0] b);
    return {a > b, a >= b, a < b, a <= b, a == b, a != b};
  endfunction

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done0 && done1) begin
        checks++;
        failures++;
        $display("FAIL done_exclusive: done0=%0b done1=%0b", done0, done1);
      end
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with empty scoreboard", done0, done1);
        end else begin
          e = sb.pop_front();
          chk("sb_port",  {7'd0, done1}, {7'd0, e.port});
          chk("sb_flags", {2'd0, flags}, {2'd0, e.flags});
          chk("sb_count", cmp_count, e.count);
        end
      end
    end
  end

  task automatic expect_cmp(input bit port, input logic [5:0] f);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.port  = port;
    e.flags = f;
    e.count = exp_count;
    sb.push_back(e);
  endtask

  // One comparison: sampling edge, EVAL edge, RESP edge; returns back in IDLE
  task automatic issue(input bit port, input logic [2:0] a, input logic [2:0] b,
                       input logic [5:0] f);
    expect_cmp(port, f);
    @(negedge CLK);
    if (port) begin req1 = 1'b1; valA1 = a; valB1 = b; end
    else      begin req0 = 1'b1; valA0 = a; valB0 = b; end
    @(posedge CLK); #1;
    req0 = 1'b0; req1 = 1'b0;
    valA0 = ~a; valB0 = ~b; valA1 = ~a; valB1 = ~b;
    chk("busy_eval", {7'd0, busy}, 8'd1);
    chk("done_early", {6'd0, done1, done0}, 8'd0);
    @(posedge CLK); #1;
    chk("done_latency", {6'd0, done1, done0}, port ? 8'd2 : 8'd1);
    @(posedge CLK); #1;
    chk("busy_idle", {7'd0, busy}, 8'd0);
    chk("done_clear", {6'd0, done1, done0}, 8'd0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    exp_count = 8'd0;
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    valA0 = '0; valB0 = '0; valA1 = '0; valB1 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_flags", {2'd0, flags}, 8'd0);
    chk("rst_done",  {6'd0, done1, done0}, 8'd0);
    chk("rst_busy",  {7'd0, busy}, 8'd0);
    chk("rst_count", cmp_count, 8'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic vectors and boundaries
    issue(1'b0, 3'd5, 3'd3, 6'b110001);
    chk("count_after_first", cmp_count, 8'd1);
    issue(1'b1, 3'd2, 3'd2, 6'b010110);
    issue(1'b0, 3'd0, 3'd7, 6'b001101);
    issue(1'b1, 3'd7, 3'd0, 6'b110001);
    // Flags hold while idle
    repeat (3) @(posedge CLK);
    #1;
    chk("flags_hold", {2'd0, flags}, 8'b00110001);
    chk("count_hold", cmp_count, 8'd4);

    // Reset during EVAL aborts the comparison
    @(negedge CLK);
    req0 = 1'b1; valA0 = 3'd6; valB0 = 3'd2;
    @(posedge CLK); #2;
    req0 = 1'b0;
    RST = 1'b1;
    exp_count = 8'd0;
    #2;
    chk("abort_busy_in_rst", {7'd0, busy}, 8'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_flags", {2'd0, flags}, 8'd0);
    chk("abort_count", cmp_count, 8'd0);
    chk("abort_busy",  {7'd0, busy}, 8'd0);

    // Contention: both requests held for 9 cycles
`ifdef ROUND_ROBIN_EN
    expect_cmp(1'b0, 6'b001101);
    expect_cmp(1'b1, 6'b010110);
    expect_cmp(1'b0, 6'b001101);
`else
    expect_cmp(1'b0, 6'b001101);
    expect_cmp(1'b0, 6'b001101);
    expect_cmp(1'b0, 6'b001101);
`endif
    @(negedge CLK);
    req0 = 1'b1; valA0 = 3'd1; valB0 = 3'd4;
    req1 = 1'b1; valA1 = 3'd6; valB1 = 3'd6;
    repeat (9) @(posedge CLK);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    chk("contention_count", cmp_count, 8'd3);
    chk("contention_idle",  {7'd0, busy}, 8'd0);

    // 256 back-to-back comparisons from reset
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ia;
      logic [7:0] ib;
      ia = 8'(i);
      ib = 8'(i * 3);
      issue(ia[0], ia[2:0], ib[2:0], ref_flags(ia[2:0], ib[2:0]));
    end
    chk("wrap_count", cmp_count, 8'd0);
    chk("wrap_flags", {2'd0, flags}, 8'b00110001);

    repeat (4) @(posedge CLK);
    #1;
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
